// File: rtl/multichannel_capture_core.sv
// Multichannel circular capture buffer with a programmable pre-trigger depth and a
// signed level-crossing trigger on a selectable channel; host reads back in time order.
module multichannel_capture_core #(
  parameter int NUM_CH     = 2,
  parameter int CH_WIDTH   = 18,
  parameter int ADDR_WIDTH = 10
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clk_enable,
  input  logic [NUM_CH*CH_WIDTH-1:0]   ch_data,
  input  logic                         arm,
  input  logic [2:0]                   trig_ch_sel,
  input  logic [1:0]                   trig_mode,
  input  logic [CH_WIDTH-1:0]          trig_level,
  input  logic [ADDR_WIDTH-1:0]        pretrig_len,
  output logic                         ready_to_capture,
  output logic                         capture_done,
  output logic [ADDR_WIDTH-1:0]        trig_addr,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic                         rd_en,
  output logic [NUM_CH*CH_WIDTH-1:0]   rd_data,
  output logic                         rd_valid
);
  // state     | meaning
  // IDLE      | no capture since reset
  // PRE_FILL  | writing the pre-trigger history, trigger ignored
  // WAIT_TRIG | writing and testing each sample for the trigger
  // POST      | writing the remaining post-trigger samples
  // DONE      | buffer frozen, read port open, re-arm allowed

  localparam int DW    = NUM_CH * CH_WIDTH;
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_ONE    = ADDR_WIDTH'(1);
  localparam logic [3:0]            NUM_CH_W = 4'(NUM_CH);

  typedef enum logic [2:0] {IDLE, PRE_FILL, WAIT_TRIG, POST, DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   wptr_q, wptr_d;
  logic [ADDR_WIDTH-1:0]   pre_len_q, pre_len_d;
  logic [ADDR_WIDTH-1:0]   pre_cnt_q, pre_cnt_d;
  logic [ADDR_WIDTH-1:0]   post_cnt_q, post_cnt_d;
  logic [ADDR_WIDTH-1:0]   trig_addr_q, trig_addr_d;
  logic [CH_WIDTH-1:0]     prev_q, prev_d;
  logic                    have_prev_q, have_prev_d;
  logic [2:0]              cfg_ch_q, cfg_ch_d;
  logic [1:0]              cfg_mode_q, cfg_mode_d;
  logic [CH_WIDTH-1:0]     cfg_level_q, cfg_level_d;
  logic [DW-1:0]           rd_data_q, rd_data_d;
  logic                    rd_valid_q, rd_valid_d;
  logic                    ready_q, ready_d;
  logic                    done_q, done_d;

  logic [DW-1:0]           mem [DEPTH];
  logic                    we;
  logic [CH_WIDTH-1:0]     cur;
  logic                    rise, fall, hit;
  logic [ADDR_WIDTH-1:0]   post_init;
  logic [ADDR_WIDTH-1:0]   rd_phys;

  always_comb begin
    cur = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (cfg_ch_q == 3'(k)) cur = ch_data[k*CH_WIDTH +: CH_WIDTH];
    end
    rise = have_prev_q && ($signed(prev_q) <  $signed(cfg_level_q)) && ($signed(cur) >= $signed(cfg_level_q));
    fall = have_prev_q && ($signed(prev_q) >= $signed(cfg_level_q)) && ($signed(cur) <  $signed(cfg_level_q));
    case (cfg_mode_q)
      2'b00:   hit = 1'b1;
      2'b01:   hit = rise;
      2'b10:   hit = fall;
      default: hit = rise | fall;
    endcase
    // Samples still owed after the trigger sample: DEPTH - pre - 1, i.e. the bitwise inverse.
    post_init = ~pre_len_q;
    rd_phys   = trig_addr_q - pre_len_q + rd_addr;

    state_d     = state_q;
    wptr_d      = wptr_q;
    pre_len_d   = pre_len_q;
    pre_cnt_d   = pre_cnt_q;
    post_cnt_d  = post_cnt_q;
    trig_addr_d = trig_addr_q;
    prev_d      = prev_q;
    have_prev_d = have_prev_q;
    cfg_ch_d    = cfg_ch_q;
    cfg_mode_d  = cfg_mode_q;
    cfg_level_d = cfg_level_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    we          = 1'b0;

    case (state_q)
      IDLE, DONE: begin
        if (arm) begin
          state_d     = PRE_FILL;
          wptr_d      = '0;
          pre_len_d   = pretrig_len;
          pre_cnt_d   = pretrig_len;
          post_cnt_d  = '0;
          have_prev_d = 1'b0;
          cfg_ch_d    = ({1'b0, trig_ch_sel} >= NUM_CH_W) ? 3'd0 : trig_ch_sel;
          cfg_mode_d  = trig_mode;
          cfg_level_d = trig_level;
        end
      end
      PRE_FILL: begin
        if (pre_cnt_q == '0) begin
          state_d = WAIT_TRIG;
        end else if (clk_enable) begin
          we        = 1'b1;
          pre_cnt_d = pre_cnt_q - A_ONE;
          if (pre_cnt_q == A_ONE) state_d = WAIT_TRIG;
        end
      end
      WAIT_TRIG: begin
        if (clk_enable) begin
          we = 1'b1;
          if (hit) begin
            trig_addr_d = wptr_q;
            post_cnt_d  = post_init;
            state_d     = (post_init == '0) ? DONE : POST;
          end
        end
      end
      POST: begin
        if (clk_enable) begin
          we         = 1'b1;
          post_cnt_d = post_cnt_q - A_ONE;
          if (post_cnt_q == A_ONE) state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (we) begin
      wptr_d      = wptr_q + A_ONE;
      prev_d      = cur;
      have_prev_d = 1'b1;
    end

    if (rd_en && state_q == DONE) begin
      rd_valid_d = 1'b1;
      rd_data_d  = mem[rd_phys];
    end

    ready_d = (state_d == WAIT_TRIG);
    done_d  = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      pre_len_q   <= '0;
      pre_cnt_q   <= '0;
      post_cnt_q  <= '0;
      trig_addr_q <= '0;
      prev_q      <= '0;
      have_prev_q <= 1'b0;
      cfg_ch_q    <= '0;
      cfg_mode_q  <= '0;
      cfg_level_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      pre_len_q   <= pre_len_d;
      pre_cnt_q   <= pre_cnt_d;
      post_cnt_q  <= post_cnt_d;
      trig_addr_q <= trig_addr_d;
      prev_q      <= prev_d;
      have_prev_q <= have_prev_d;
      cfg_ch_q    <= cfg_ch_d;
      cfg_mode_q  <= cfg_mode_d;
      cfg_level_q <= cfg_level_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
    end
  end

  // Sample RAM is never cleared; only the pointers reset.
  always_ff @(posedge clk) begin
    if (we && !reset) mem[wptr_q] <= ch_data;
  end

  assign ready_to_capture = ready_q;
  assign capture_done     = done_q;
  assign trig_addr        = trig_addr_q;
  assign rd_data          = rd_data_q;
  assign rd_valid         = rd_valid_q;
endmodule
